multdiv_issue: RTL and testbench

Pipeline-side initiator for the multi-cycle multiply/divide unit. Accepts a mult or div instruction from the execute stage and launches it with a one-cycle start pulse. Holds the operands stable and stalls the pipeline until result-ready or a watchdog timeout, then emits a single writeback beat. An exception or timeout redirects that beat to $rstatus (r30).

---
 rtl/multdiv_issue_if.sv | 36 +++
 rtl/multdiv_issue.sv | 130 +++++++++++++
 tb/tb_multdiv_issue.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/multdiv_issue_if.sv
// Pipeline-side and unit-side signals of the multiply/divide issue block.
// slave is the issue block itself; master is whoever drives it (pipeline + unit).
interface multdiv_issue_if;
  logic        req_valid;
  logic        req_is_mult;
  logic        req_is_div;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [4:0]  req_rd;
  logic        flush;
  logic [31:0] md_operandA;
  logic [31:0] md_operandB;
  logic        md_ctrl_MULT;
  logic        md_ctrl_DIV;
  logic [31:0] md_result;
  logic        md_exception;
  logic        md_resultRDY;
  logic        stall;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  modport slave (
    input  req_valid, req_is_mult, req_is_div, req_a, req_b, req_rd, flush,
    input  md_result, md_exception, md_resultRDY,
    output md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV,
    output stall, wb_valid, wb_rd, wb_data
  );

  modport master (
    output req_valid, req_is_mult, req_is_div, req_a, req_b, req_rd, flush,
    output md_result, md_exception, md_resultRDY,
    input  md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV,
    input  stall, wb_valid, wb_rd, wb_data
  );
endinterface

// File: rtl/multdiv_issue.sv
// Issues one mult/div to the multi-cycle unit, stalls until result or watchdog,
// then emits a single writeback beat (redirected to r30 on exception/timeout).
//
// state | meaning
// IDLE  | waiting for a mult/div from execute
// START | one-cycle start pulse to the unit
// WAIT  | polling md_resultRDY, watchdog counting
// DONE  | single writeback beat, pipeline released
module multdiv_issue #(
  parameter int unsigned TIMEOUT = 40
) (
  input  logic            clock,
  input  logic            resetn,
  multdiv_issue_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

  localparam logic [5:0] CNT_LAST = 6'(TIMEOUT - 1);
  localparam logic [4:0] RSTATUS  = 5'd30;

  state_t      state, state_nxt;
  logic        accept;
  logic [5:0]  cnt;
  logic        op_div;
  logic [4:0]  rd_q;
  logic [31:0] opa_q, opb_q;
  logic [31:0] res_q;
  logic        exc_q, tmo_q;
  logic        wb_write;

  assign accept   = bus.req_valid & (bus.req_is_mult | bus.req_is_div) & ~bus.flush;
  assign wb_write = (rd_q != 5'd0) | exc_q | tmo_q;

  assign bus.md_operandA = opa_q;
  assign bus.md_operandB = opb_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_nxt = START;
        START:   state_nxt = WAIT;
        WAIT:    if (bus.md_resultRDY || cnt == CNT_LAST) state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Operands stay on the unit's inputs until the next acceptance.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt    <= 6'd0;
      op_div <= 1'b0;
      rd_q   <= 5'd0;
      opa_q  <= 32'd0;
      opb_q  <= 32'd0;
      res_q  <= 32'd0;
      exc_q  <= 1'b0;
      tmo_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            opa_q  <= bus.req_a;
            opb_q  <= bus.req_b;
            rd_q   <= bus.req_rd;
            op_div <= bus.req_is_div;
          end
        end
        START: begin
          cnt   <= 6'd0;
          exc_q <= 1'b0;
          tmo_q <= 1'b0;
        end
        WAIT: begin
          cnt <= cnt + 6'd1;
          if (bus.md_resultRDY) begin
            res_q <= bus.md_result;
            exc_q <= bus.md_exception;
          end else if (cnt == CNT_LAST) begin
            tmo_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.stall        = 1'b0;
    bus.md_ctrl_MULT = 1'b0;
    bus.md_ctrl_DIV  = 1'b0;
    bus.wb_valid     = 1'b0;
    bus.wb_rd        = 5'd0;
    bus.wb_data      = 32'd0;
    case (state)
      IDLE:  bus.stall = accept;
      START: begin
        bus.stall        = 1'b1;
        bus.md_ctrl_MULT = ~op_div & ~bus.flush;
        bus.md_ctrl_DIV  = op_div & ~bus.flush;
      end
      WAIT:  bus.stall = 1'b1;
      DONE: begin
        bus.wb_valid = wb_write & ~bus.flush;
        if (tmo_q) begin
          bus.wb_rd   = RSTATUS;
          bus.wb_data = 32'd6;
        end else if (exc_q) begin
          bus.wb_rd   = RSTATUS;
          bus.wb_data = op_div ? 32'd5 : 32'd4;
        end else begin
          bus.wb_rd   = rd_q;
          bus.wb_data = res_q;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multdiv_issue.sv
// Bench for multdiv_issue: each operation is described as a timeline relative to
// its acceptance cycle, and a negedge process compares the DUT against it.
module tb_multdiv_issue;
  localparam int T = 40;

  logic clock = 1'b0;
  logic resetn;

  multdiv_issue_if bus();

  multdiv_issue #(.TIMEOUT(T)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  logic        exp_stall, exp_mult, exp_div, exp_wbv;
  logic [4:0]  exp_rd;
  logic [31:0] exp_data, exp_a, exp_b;
  logic [31:0] prev_a = 32'd0, prev_b = 32'd0;

  int          wb_cnt = 0, stall_cnt = 0, mult_cnt = 0, div_cnt = 0;
  logic [4:0]  cap_rd = 5'd0;
  logic [31:0] cap_data = 32'd0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      check("stall", 32'(bus.stall), 32'(exp_stall));
      check("ctrl_mult", 32'(bus.md_ctrl_MULT), 32'(exp_mult));
      check("ctrl_div", 32'(bus.md_ctrl_DIV), 32'(exp_div));
      check("operand_a", bus.md_operandA, exp_a);
      check("operand_b", bus.md_operandB, exp_b);
      check("wb_valid", 32'(bus.wb_valid), 32'(exp_wbv));
      if (exp_wbv) begin
        check("wb_rd", 32'(bus.wb_rd), 32'(exp_rd));
        check("wb_data", bus.wb_data, exp_data);
      end
      if (bus.wb_valid === 1'b1) begin
        wb_cnt++;
        cap_rd   = bus.wb_rd;
        cap_data = bus.wb_data;
      end
      if (bus.stall === 1'b1)        stall_cnt++;
      if (bus.md_ctrl_MULT === 1'b1) mult_cnt++;
      if (bus.md_ctrl_DIV === 1'b1)  div_cnt++;
    end
  end

  task automatic set_idle_exp();
    exp_stall = 1'b0;
    exp_mult  = 1'b0;
    exp_div   = 1'b0;
    exp_wbv   = 1'b0;
    exp_rd    = 5'd0;
    exp_data  = 32'd0;
    exp_a     = prev_a;
    exp_b     = prev_b;
  endtask

  // lat: result-ready L cycles after the start pulse (0 = never);
  // fk/rk: cycle of flush / reset relative to acceptance (-1 = none).
  task automatic run_op(input bit is_mult, input bit is_div, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input int lat,
                        input bit exc, input int fk, input int rk, input bit start_rdy);
    bit          tmo, wbv, killed, pulse, rdy_now;
    int          done_k, last_k;
    logic [31:0] res, wdata;
    logic [4:0]  wrd;
    tmo    = !(lat >= 1 && lat <= T);
    done_k = tmo ? 2 + T : 2 + lat;
    res    = is_div ? ((b == 32'd0) ? 32'd0 : a / b) : a * b;
    if (tmo) begin
      wrd = 5'd30; wdata = 32'd6;
    end else if (exc) begin
      wrd = 5'd30; wdata = is_div ? 32'd5 : 32'd4;
    end else begin
      wrd = rd; wdata = res;
    end
    wbv    = tmo || exc || (rd != 5'd0);
    last_k = (rk >= 0) ? rk + 3 : (fk >= 0) ? fk + 3 : done_k + 1;
    for (int k = 0; k <= last_k; k++) begin
      @(posedge clock); #1;
      killed  = (fk >= 0 && k > fk) || (rk >= 0 && k >= rk);
      rdy_now = !tmo && (k == 1 + lat);
      if (rk >= 0 && k == rk)     resetn = 1'b0;
      if (rk >= 0 && k == rk + 2) resetn = 1'b1;
      bus.req_valid    = !killed && (k <= done_k);
      bus.req_is_mult  = is_mult;
      bus.req_is_div   = is_div;
      bus.req_a        = a;
      bus.req_b        = b;
      bus.req_rd       = rd;
      bus.flush        = (k == fk);
      bus.md_resultRDY = rdy_now || (start_rdy && k == 1) || (fk >= 0 && k == fk + 2);
      bus.md_result    = rdy_now ? res : $urandom;
      bus.md_exception = rdy_now ? exc : 1'($urandom_range(0, 1));
      exp_stall = !killed && (k < done_k) && !(k == 0 && fk == 0);
      pulse     = (k == 1) && !killed && (fk != 1);
      exp_mult  = pulse && !is_div;
      exp_div   = pulse && is_div;
      if (rk >= 0 && k >= rk) begin
        exp_a = 32'd0; exp_b = 32'd0;
      end else if (k >= 1 && fk != 0) begin
        exp_a = a; exp_b = b;
      end else begin
        exp_a = prev_a; exp_b = prev_b;
      end
      exp_wbv  = (k == done_k) && !killed && (fk != k) && wbv;
      exp_rd   = wrd;
      exp_data = wdata;
    end
    if (rk >= 0) begin
      prev_a = 32'd0; prev_b = 32'd0;
    end else if (fk != 0) begin
      prev_a = a; prev_b = b;
    end
    set_idle_exp();
  endtask

  int wb0;

  initial begin
    resetn           = 1'b0;
    bus.req_valid    = 1'b0;
    bus.req_is_mult  = 1'b0;
    bus.req_is_div   = 1'b0;
    bus.req_a        = 32'd0;
    bus.req_b        = 32'd0;
    bus.req_rd       = 5'd0;
    bus.flush        = 1'b0;
    bus.md_result    = 32'd0;
    bus.md_exception = 1'b0;
    bus.md_resultRDY = 1'b0;
    set_idle_exp();
    chk_en = 1'b1;
    repeat (3) @(posedge clock);
    #1 resetn = 1'b1;

    // mult 7x6 -> r5, result after 32 cycles
    stall_cnt = 0; mult_cnt = 0; wb0 = wb_cnt;
    run_op(1, 0, 32'd7, 32'd6, 5'd5, 32, 0, -1, -1, 0);
    check("lit_mult_data", cap_data, 32'd42);
    check("lit_mult_rd", 32'(cap_rd), 32'd5);
    check("lit_mult_stall_cycles", 32'(stall_cnt), 32'd34);
    check("lit_mult_pulses", 32'(mult_cnt), 32'd1);
    check("lit_mult_wb_count", 32'(wb_cnt - wb0), 32'd1);

    // divide by zero with exception -> r30 = 5
    wb0 = wb_cnt;
    run_op(0, 1, 32'd100, 32'd0, 5'd9, 5, 1, -1, -1, 0);
    check("lit_divexc_rd", 32'(cap_rd), 32'd30);
    check("lit_divexc_data", cap_data, 32'd5);
    check("lit_divexc_wb_count", 32'(wb_cnt - wb0), 32'd1);

    // no result ever -> watchdog
    stall_cnt = 0;
    run_op(0, 1, 32'd9, 32'd3, 5'd11, 0, 0, -1, -1, 0);
    check("lit_tmo_rd", 32'(cap_rd), 32'd30);
    check("lit_tmo_data", cap_data, 32'd6);
    check("lit_tmo_stall_cycles", 32'(stall_cnt), 32'd42);

    // flush during START, stray RDY afterwards
    wb0 = wb_cnt; mult_cnt = 0;
    run_op(1, 0, 32'd3, 32'd4, 5'd7, 10, 0, 1, -1, 0);
    check("lit_flush_wb_count", 32'(wb_cnt - wb0), 32'd0);
    check("lit_flush_pulses", 32'(mult_cnt), 32'd0);

    // flush in IDLE beats acceptance
    wb0 = wb_cnt;
    run_op(0, 1, 32'd8, 32'd2, 5'd3, 4, 0, 0, -1, 0);
    check("lit_idleflush_wb_count", 32'(wb_cnt - wb0), 32'd0);

    // rd = 0 writeback suppressed
    wb0 = wb_cnt;
    run_op(1, 0, 32'd5, 32'd5, 5'd0, 3, 0, -1, -1, 0);
    check("lit_rd0_wb_count", 32'(wb_cnt - wb0), 32'd0);

    // RDY during START ignored
    run_op(1, 0, 32'd11, 32'd13, 5'd2, 3, 0, -1, -1, 1);
    check("lit_startrdy_data", cap_data, 32'd143);

    // reset mid-WAIT, then both selects high -> div
    run_op(1, 0, 32'd21, 32'd2, 5'd4, 20, 0, -1, 5, 0);
    div_cnt = 0; mult_cnt = 0;
    run_op(1, 1, 32'd50, 32'd7, 5'd12, 4, 0, -1, -1, 0);
    check("lit_both_div_pulses", 32'(div_cnt), 32'd1);
    check("lit_both_mult_pulses", 32'(mult_cnt), 32'd0);
    check("lit_both_data", cap_data, 32'd7);
    check("lit_both_rd", 32'(cap_rd), 32'd12);

    // valid without an op select is not accepted
    @(posedge clock); #1;
    bus.req_valid = 1'b1; bus.req_is_mult = 1'b0; bus.req_is_div = 1'b0;
    repeat (3) @(posedge clock);
    #1 bus.req_valid = 1'b0;

    for (int i = 0; i < 40; i++) begin
      int          sel, lat, fk;
      bit          m, d, exc;
      logic [31:0] a, b;
      sel = $urandom_range(0, 2);
      m   = (sel != 1);
      d   = (sel != 0);
      a   = $urandom;
      b   = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      exc = ($urandom_range(0, 7) == 0) || (d && b == 32'd0);
      lat = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 44);
      fk  = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 3) : -1;
      run_op(m, d, a, b, 5'($urandom_range(0, 31)), lat, exc, fk, -1,
             1'($urandom_range(0, 1)));
    end

    @(posedge clock); #1;
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
